// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM sequencing PC, IR, GRF, ALU, EXT and unified memory
//
// Optional feature macro: MC_CTRL_INSTR_CNT_EN (adds retired-instruction counter output instr_cnt)
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   opcode     IR[31:26]
//   func       IR[5:0]
//   zero       ALU result == 0
//   mem_ready  memory completes the current request this cycle
//   mem_req    memory request valid
//   mem_we     1 = store, 0 = load/fetch
//   pc_we      PC write enable
//   npc_sel    0 = PC+4, 1 = branch, 2 = j-index, 3 = rs
//   ir_we      IR write enable
//   reg_we     GRF write enable
//   reg_dst    0 = rt, 1 = rd, 2 = $31
//   wd_sel     0 = ALU, 1 = MEM, 2 = PC
//   alu_src    0 = rt data, 1 = EXT imm
//   alu_op     0 = ADD, 1 = SUB, 2 = OR, 3 = LUI
//   ext_op     0 = zero-extend, 1 = sign-extend
//   illegal    one-cycle pulse in S_DECODE on an unknown opcode/func
//   error      sticky memory timeout flag
//   state      current FSM state
//   instr_cnt  retired instruction count (only with MC_CTRL_INSTR_CNT_EN)

module mc_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        ext_op,
    output logic        illegal,
    output logic        error,
    output logic [2:0]  state
`ifdef MC_CTRL_INSTR_CNT_EN
    ,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] wait_cnt;

    // Instruction decode from the IR fields
    logic is_r, is_add, is_sub, is_jr, is_nop;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_known;
    logic timed_out;

    always_comb begin
        is_r     = (opcode == 6'b000000);
        is_add   = is_r && (func == 6'b100000);
        is_sub   = is_r && (func == 6'b100010);
        is_jr    = is_r && (func == 6'b001000);
        is_nop   = is_r && (func == 6'b000000);
        is_ori   = (opcode == 6'b001101);
        is_lui   = (opcode == 6'b001111);
        is_lw    = (opcode == 6'b100011);
        is_sw    = (opcode == 6'b101011);
        is_beq   = (opcode == 6'b000100);
        is_jal   = (opcode == 6'b000011);
        is_known = is_add | is_sub | is_jr | is_nop | is_ori | is_lui |
                   is_lw | is_sw | is_beq | is_jal;
        // A ready in the same cycle as the limit is reached wins over the timeout
        timed_out = (wait_cnt >= TIMEOUT_C) && !mem_ready;
    end

    always_comb begin
        nxt     = cur;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        pc_we   = 1'b0;
        npc_sel = 2'd0;
        ir_we   = 1'b0;
        reg_we  = 1'b0;
        reg_dst = 2'd0;
        wd_sel  = 2'd0;
        alu_src = 1'b0;
        alu_op  = 2'd0;
        ext_op  = 1'b0;
        illegal = 1'b0;
        error   = 1'b0;

        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = S_DECODE;
                end else if (timed_out) begin
                    nxt = S_ERR;
                end
            end
            S_DECODE: begin
                if (is_jal) begin
                    reg_we  = 1'b1;
                    reg_dst = 2'd2;
                    wd_sel  = 2'd2;
                    pc_we   = 1'b1;
                    npc_sel = 2'd2;
                    nxt     = S_FETCH;
                end else if (is_jr) begin
                    pc_we   = 1'b1;
                    npc_sel = 2'd3;
                    nxt     = S_FETCH;
                end else if (is_nop) begin
                    nxt = S_FETCH;
                end else if (!is_known) begin
                    illegal = 1'b1;
                    nxt     = S_FETCH;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_add) begin
                    nxt = S_WB;
                end else if (is_sub) begin
                    alu_op = 2'd1;
                    nxt    = S_WB;
                end else if (is_ori) begin
                    alu_op  = 2'd2;
                    alu_src = 1'b1;
                    nxt     = S_WB;
                end else if (is_lui) begin
                    alu_op  = 2'd3;
                    alu_src = 1'b1;
                    nxt     = S_WB;
                end else if (is_lw || is_sw) begin
                    alu_src = 1'b1;
                    ext_op  = 1'b1;
                    nxt     = S_MEM;
                end else if (is_beq) begin
                    alu_op  = 2'd1;
                    ext_op  = 1'b1;
                    pc_we   = zero;
                    npc_sel = 2'd1;
                    nxt     = S_FETCH;
                end else begin
                    // Unreachable via S_DECODE; recover to fetch
                    nxt = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    nxt = is_sw ? S_FETCH : S_WB;
                end else if (timed_out) begin
                    nxt = S_ERR;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                if (is_lw) begin
                    wd_sel = 2'd1;
                end else if (is_r) begin
                    reg_dst = 2'd1;
                end
                nxt = S_FETCH;
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: begin
                nxt = S_FETCH;
            end
        endcase

        // Outputs are held quiet for as long as reset is asserted
        if (!reset_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            pc_we   = 1'b0;
            npc_sel = 2'd0;
            ir_we   = 1'b0;
            reg_we  = 1'b0;
            reg_dst = 2'd0;
            wd_sel  = 2'd0;
            alu_src = 1'b0;
            alu_op  = 2'd0;
            ext_op  = 1'b0;
            illegal = 1'b0;
            error   = 1'b0;
        end
    end

    assign state = cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur) begin
                wait_cnt <= '0;
            end else if (wait_cnt < TIMEOUT_C) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

`ifdef MC_CTRL_INSTR_CNT_EN
    // Every return to fetch marks one retired instruction (nop and illegal included)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_cnt <= 32'd0;
        end else if (nxt == S_FETCH && cur != S_FETCH) begin
            instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl against an instruction-level schedule model

module tb_mc_ctrl;

    localparam int TO = 255;

    localparam int C_ADD = 0, C_SUB = 1, C_ORI = 2, C_LUI = 3, C_LW = 4, C_SW = 5;
    localparam int C_BEQ = 6, C_JAL = 7, C_JR = 8, C_NOP = 9, C_ILL = 10;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       pc_we;
        logic [1:0] npc_sel;
        logic       ir_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       ext_op;
        logic       illegal;
        logic       error;
    } outs_t;

    typedef struct {
        outs_t       o;
        logic        rdy;
        logic        z;
        logic [5:0]  op;
        logic [5:0]  fn;
        int unsigned cnt;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  func = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, pc_we, ir_we, reg_we, alu_src, ext_op, illegal, error;
    logic [1:0]  npc_sel, reg_dst, wd_sel, alu_op;
    logic [2:0]  state;
`ifdef MC_CTRL_INSTR_CNT_EN
    logic [31:0] instr_cnt;
`endif

    outs_t got;
    assign got = {state, mem_req, mem_we, pc_we, npc_sel, ir_we, reg_we,
                  reg_dst, wd_sel, alu_src, alu_op, ext_op, illegal, error};

    mc_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .func      (func),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .pc_we     (pc_we),
        .npc_sel   (npc_sel),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .ext_op    (ext_op),
        .illegal   (illegal),
        .error     (error),
        .state     (state)
`ifdef MC_CTRL_INSTR_CNT_EN
        ,
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    rec_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned retired = 0;
    int          ill_exp = 0;
    int          ill_seen = 0;
    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;
    logic        cur_z = 1'b0;
    string       tname = "";

    function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                6'h20:   return C_ADD;
                6'h22:   return C_SUB;
                6'h08:   return C_JR;
                6'h00:   return C_NOP;
                default: return C_ILL;
            endcase
            6'h0d:   return C_ORI;
            6'h0f:   return C_LUI;
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h04:   return C_BEQ;
            6'h03:   return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input outs_t o, input logic rdy);
        rec_t r;
        r.o = o; r.rdy = rdy; r.z = cur_z; r.op = cur_op; r.fn = cur_fn; r.cnt = retired;
        q.push_back(r);
    endtask

    // Expand one instruction into its expected per-cycle outputs
    task automatic gen(input logic [31:0] ins, input logic z, input int fw, input int mw);
        outs_t o;
        int c;
        cur_op = ins[31:26]; cur_fn = ins[5:0]; cur_z = z;
        c = cls(cur_op, cur_fn);
        for (int i = 0; i < fw; i++) begin
            o = '0; o.mem_req = 1'b1; push(o, 1'b0);
        end
        o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1; push(o, 1'b1);
        o = '0; o.st = 3'd1;
        case (c)
            C_JAL: begin o.reg_we = 1; o.reg_dst = 2; o.wd_sel = 2; o.pc_we = 1; o.npc_sel = 2; end
            C_JR:  begin o.pc_we = 1; o.npc_sel = 3; end
            C_ILL: begin o.illegal = 1; ill_exp++; end
            default: ;
        endcase
        push(o, 1'b1);
        if (c == C_JAL || c == C_JR || c == C_NOP || c == C_ILL) begin
            retired++;
            return;
        end
        o = '0; o.st = 3'd2;
        case (c)
            C_SUB: o.alu_op = 1;
            C_ORI: begin o.alu_op = 2; o.alu_src = 1; end
            C_LUI: begin o.alu_op = 3; o.alu_src = 1; end
            C_LW, C_SW: begin o.alu_src = 1; o.ext_op = 1; end
            C_BEQ: begin o.alu_op = 1; o.ext_op = 1; o.pc_we = z; o.npc_sel = 1; end
            default: ;
        endcase
        push(o, 1'b1);
        if (c == C_BEQ) begin
            retired++;
            return;
        end
        if (c == C_LW || c == C_SW) begin
            o = '0; o.st = 3'd3; o.mem_req = 1; o.mem_we = (c == C_SW);
            for (int i = 0; i < mw; i++) push(o, 1'b0);
            push(o, 1'b1);
            if (c == C_SW) begin
                retired++;
                return;
            end
        end
        o = '0; o.st = 3'd4; o.reg_we = 1;
        if (c == C_ADD || c == C_SUB) o.reg_dst = 1;
        if (c == C_LW) o.wd_sel = 1;
        push(o, 1'b1);
        retired++;
    endtask

    // Each record starts at posedge+1 and is compared at the following negedge
    task automatic run(input int limit);
        int n;
        n = 0;
        foreach (q[i]) begin
            if (limit >= 0 && n >= limit) break;
            opcode = q[i].op; func = q[i].fn; zero = q[i].z; mem_ready = q[i].rdy;
            @(negedge clk);
            vectors++;
            if (got !== q[i].o) begin
                miscompares++;
                $display("FAIL %s cyc%0d: outputs got %h want %h", tname, n, got, q[i].o);
            end
`ifdef MC_CTRL_INSTR_CNT_EN
            vectors++;
            if (instr_cnt !== q[i].cnt) begin
                miscompares++;
                $display("FAIL %s cyc%0d instr_cnt: got %0d want %0d", tname, n, instr_cnt, q[i].cnt);
            end
`endif
            if (illegal === 1'b1) ill_seen++;
            @(posedge clk);
            #1;
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL %s reset outputs: got %h want %h", tname, got, 20'h0);
        end
        retired = 0;
`ifdef MC_CTRL_INSTR_CNT_EN
        check_int({tname, " reset instr_cnt"}, int'(instr_cnt), 0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        outs_t o;
        int    ill0;

        @(posedge clk);
        #1;
        tname = "reset";
        do_reset();

        tname = "add";
        gen(32'h012a5020, 1'b0, 0, 0);
        check_int("add_len", q.size(), 4);
        run(-1);

        tname = "lw_wait3";
        gen(32'h8d2c1234, 1'b0, 0, 3);
        check_int("lw_len", q.size(), 8);
        run(-1);

        tname = "beq_taken";
        gen(32'h11229abc, 1'b1, 0, 0);
        check_int("beq_len", q.size(), 3);
        run(-1);
        tname = "beq_not_taken";
        gen(32'h11229abc, 1'b0, 0, 0);
        run(-1);

        tname = "jal";
        gen(32'h0c123456, 1'b0, 0, 0);
        check_int("jal_len", q.size(), 2);
        run(-1);
        tname = "jr";
        gen(32'h02a00008, 1'b0, 0, 0);
        check_int("jr_len", q.size(), 2);
        run(-1);

        tname = "sub_ori_lui";
        gen(32'h012a5022, 1'b0, 2, 0);
        gen(32'h3508ffff, 1'b0, 0, 0);
        gen(32'h3c081234, 1'b1, 1, 0);
        run(-1);

        tname = "fetch_ready_at_limit";
        gen(32'h3508ffff, 1'b0, TO, 0);
        run(-1);

        tname = "abort";
        gen(32'h012a5020, 1'b0, 0, 0);
        run(2);
        do_reset();

        tname = "mix";
        ill0 = ill_seen;
        gen(32'h012a5020, 1'b0, 0, 0);
        gen(32'h00000000, 1'b0, 0, 0);
        gen(32'had4c5678, 1'b0, 0, 1);
        gen(32'hfc000000, 1'b0, 0, 0);
        o = '0; o.mem_req = 1'b1;
        push(o, 1'b0);
        run(-1);
        check_int("mix_illegal_pulses", ill_seen - ill0, 1);
`ifdef MC_CTRL_INSTR_CNT_EN
        check_int("mix_instr_cnt", int'(instr_cnt), 4);
`endif

        tname = "timeout";
        do_reset();
        cur_op = 6'h00; cur_fn = 6'h20; cur_z = 1'b0;
        o = '0; o.mem_req = 1'b1;
        for (int i = 0; i <= TO; i++) push(o, 1'b0);
        o = '0; o.st = 3'd7; o.error = 1'b1;
        push(o, 1'b0);
        push(o, 1'b1);
        push(o, 1'b0);
        check_int("timeout_len", q.size(), 259);
        run(-1);
        do_reset();
        tname = "after_error";
        gen(32'h02a00008, 1'b0, 0, 0);
        run(-1);

        check_int("illegal_total", ill_seen, ill_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
